fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Pointer/flag controller for one side of an asynchronous FIFO. It keeps a binary pointer that advances on a valid/ready handshake and converts that pointer to Gray code with the existing `bin2gray` for export to the other clock domain. It synchronizes the remote Gray pointer into its own clock and decodes it with `gray2bin`. From these it produces a registered full (write side) or empty (read side) flag and a fill level.

## Interface
- `ADDR_W`, 4 — FIFO address width; depth = 2^ADDR_W; legal range ≥ 2.
- `IS_WRITE`, 1 — 1: write side (flag = full); 0: read side (flag = empty).
- `SYNC_STAGES`, 2 — flops in the remote-pointer synchronizer; legal range ≥ 2.

Ports:
- `clk` in 1 — local clock.
- `rst_n` in 1 — reset: asynchronous, active-low.
- `inc_valid` in 1 — request to write or read one entry.
- `inc_ready` out 1 — `~flag_out`; an accept is `inc_valid & inc_ready`.
- `remote_gray_in` in ADDR_W+1 — other side's Gray pointer; asynchronous to `clk`.
- `addr_out` out ADDR_W — RAM address, equal to `bin[ADDR_W-1:0]`.
- `ptr_gray_out` out ADDR_W+1 — registered Gray pointer, exported to the other domain.
- `flag_out` out 1 — full when `IS_WRITE`=1, empty when `IS_WRITE`=0.
- `level_out` out ADDR_W+1 — write side: entries used; read side: entries available.

## Operation
- State registers: `bin` and `gray` (ADDR_W+1 bits each), the sync chain, `flag`, `level`.
- `bin_next = bin + accept`, modulo 2^(ADDR_W+1); wraps from all-ones to 0.
- `gray_next = bin2gray(bin_next)`. `gray` is registered directly from `gray_next` and is never derived from registered `bin`, so the exported pointer changes at most one bit per cycle.
- `rsync` is the last stage of the `SYNC_STAGES`-flop chain on `remote_gray_in`. `rbin = gray2bin(rsync)`.
- Write-side full: `gray_next == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]}`.
- Read-side empty: `gray_next == rsync`.
- Level:
  - write side: `bin_next - rbin` (mod 2^(ADDR_W+1));
  - read side: `rbin - bin_next`.
- `flag` and `level` are registered from next-state values, so they are correct in the cycle after an accept.
- Flags are pessimistic: a remote update frees space or data only after synchronization. Overflow and underflow are impossible by construction.
- `inc_valid` while `inc_ready`=0: no accept and no state change. The requester may drop `inc_valid` at any time.

## Timing
- Reset values:
  - `bin`, `gray`, sync chain, `addr_out`, `ptr_gray_out`, `level_out`: 0;
  - `flag_out`: 0 on the write side, 1 on the read side;
  - `inc_ready`: the inverse of `flag_out`.
- Reset asserted mid-operation clears everything immediately (asynchronous), regardless of a pending accept. Release is synchronous to `clk`.
- Local accept in cycle t:
  - `addr_out` and `ptr_gray_out` update at edge t+1;
  - `flag_out` and `level_out` reflect the accept at edge t+1;
  - back-to-back accepts are sustained at 1 per cycle until the flag asserts.
- Remote pointer change: visible in `flag_out` and `level_out` SYNC_STAGES+1 edges later (3 with default settings).
- An accept and a remote change in the same cycle are both applied; the flag is computed from both.

## Structure
- Package `fifo_ptr_pkg`:
  - `ptr_t`, a parameterized-width logic vector typedef;
  - localparams `FULL_RST` = 0 and `EMPTY_RST` = 1.
- Reuse the existing `bin2gray` (on `bin_next`) and `gray2bin` (on `rsync`) modules with `N`=ADDR_W+1.
- One new sub-module: `ptr_sync`, a `SYNC_STAGES`-deep, ADDR_W+1-wide flop chain with asynchronous active-low reset to 0.
- The top-level module is target 150–250 lines.

## Test plan
- **Write-side fill.** `IS_WRITE`=1, `ADDR_W`=4, remote held at 0. Hold `inc_valid` for 20 cycles.
  - Exactly 16 accepts occur.
  - `flag_out`=1 and `inc_ready`=0 at the edge after the 16th accept.
  - `ptr_gray_out`=5'b11000 and `level_out`=16.
  - Extra cycles do not change the pointer.
- **Write-side drain visibility.** From the full state, drive `remote_gray_in`=5'b00001 (binary 1).
  - `flag_out` stays 1 for 2 edges and drops at the 3rd edge.
  - `level_out`=15 at that edge.
- **Read-side availability.** `IS_WRITE`=0.
  - After reset: `flag_out`=1, `level_out`=0.
  - Drive `remote_gray_in`=5'b00010 (binary 3): `flag_out`=0 and `level_out`=3 three edges later.
  - Perform 3 accepts: `flag_out`=1 at the edge after the 3rd accept, and `addr_out` steps 1, 2, 3.
- **Wrap-around.** Write side with the remote tracking the local pointer (loopback with a delay). Run 40 accepts.
  - `bin` wraps 31→0 and `ptr_gray_out` goes 5'b10000→5'b00000.
  - A checker confirms exactly one bit of `ptr_gray_out` changes per accept, and no false full.
- **Stalled request.** At full, hold `inc_valid` for 10 cycles: `ptr_gray_out`, `addr_out` and `level_out` are unchanged.
- **Reset mid-operation.** At `level_out`=7, assert `rst_n`=0 between clock edges.
  - All outputs return to their reset values without waiting for a clock edge.
  - After release, the first accept gives `addr_out`=1.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Shared types and reset constants for the async-FIFO pointer controllers.
package fifo_ptr_pkg;

    localparam int  DEF_ADDR_W = 4;
    localparam int  PTR_W      = DEF_ADDR_W + 1;
    localparam logic FULL_RST  = 1'b0;
    localparam logic EMPTY_RST = 1'b1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Full resets deasserted on the write side, empty resets asserted on the read side.
    function automatic logic flag_rst(input bit is_write);
        return is_write ? FULL_RST : EMPTY_RST;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary to Gray conversion.
module bin2gray #(
    parameter int N = 5
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_ptr_ctrl_sync.sv
// Multi-flop synchronizer for the remote Gray pointer; clears to 0 on reset.
module ptr_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gray2bin.sv
// Combinational Gray to binary conversion.
module gray2bin #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    function automatic logic [N-1:0] decode(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign bin = decode(gray);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One side of an async FIFO: local binary/Gray pointer, synchronized remote
// pointer, and registered full (write) or empty (read) flag with fill level.
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter bit IS_WRITE    = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_valid,
    output logic              inc_ready,
    input  logic [ADDR_W:0]   remote_gray_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ADDR_W:0]   ptr_gray_out,
    output logic              flag_out,
    output logic [ADDR_W:0]   level_out
);

    logic [ADDR_W:0] bin;
    logic [ADDR_W:0] gray;
    logic [ADDR_W:0] bin_next;
    logic [ADDR_W:0] gray_next;
    logic [ADDR_W:0] rsync;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level;
    logic [ADDR_W:0] level_next;
    logic            flag;
    logic            flag_next;
    logic            accept;

    assign accept   = inc_valid & ~flag;
    assign bin_next = bin + {{ADDR_W{1'b0}}, accept};

    bin2gray #(.N(ADDR_W + 1)) u_bin2gray (
        .bin  (bin_next),
        .gray (gray_next)
    );

    ptr_sync #(.W(ADDR_W + 1), .STAGES(SYNC_STAGES)) u_ptr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (remote_gray_in),
        .q     (rsync)
    );

    gray2bin #(.N(ADDR_W + 1)) u_gray2bin (
        .gray (rsync),
        .bin  (rbin)
    );

    // Flags compare next-state Gray against the synchronized remote pointer,
    // so they are pessimistic but never allow overflow or underflow.
    generate
        if (IS_WRITE) begin : g_write
            assign flag_next  = (gray_next == {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]});
            assign level_next = bin_next - rbin;
        end else begin : g_read
            assign flag_next  = (gray_next == rsync);
            assign level_next = rbin - bin_next;
        end
    endgenerate

    // Gray is registered straight from gray_next so the exported pointer
    // changes by at most one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin   <= '0;
            gray  <= '0;
            flag  <= flag_rst(IS_WRITE);
            level <= '0;
        end else begin
            bin   <= bin_next;
            gray  <= gray_next;
            flag  <= flag_next;
            level <= level_next;
        end
    end

    assign inc_ready    = ~flag;
    assign addr_out     = bin[ADDR_W-1:0];
    assign ptr_gray_out = gray;
    assign flag_out     = flag;
    assign level_out    = level;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: a write-side and a read-side instance.
module tb_fifo_ptr_ctrl;

    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       flag;
        logic [4:0] level;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_w, valid_r;
    logic [4:0] remote_w, remote_r;
    logic       ready_w, ready_r;
    logic [3:0] addr_w, addr_r;
    logic [4:0] gray_w, gray_r;
    logic       flag_w, flag_r;
    logic [4:0] level_w, level_r;

    int checks = 0;
    int errors = 0;

    exp_t q_w[$];
    exp_t q_r[$];

    // Reference state: local binary pointer, 2-deep remote sync, registered flag.
    logic [4:0] mb_w, ms0_w, ms1_w;
    logic [4:0] mb_r, ms0_r, ms1_r;
    logic       mf_w, mf_r;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.ADDR_W(4), .IS_WRITE(1'b1), .SYNC_STAGES(2)) u_wr (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_valid      (valid_w),
        .inc_ready      (ready_w),
        .remote_gray_in (remote_w),
        .addr_out       (addr_w),
        .ptr_gray_out   (gray_w),
        .flag_out       (flag_w),
        .level_out      (level_w)
    );

    fifo_ptr_ctrl #(.ADDR_W(4), .IS_WRITE(1'b0), .SYNC_STAGES(2)) u_rd (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_valid      (valid_r),
        .inc_ready      (ready_r),
        .remote_gray_in (remote_r),
        .addr_out       (addr_r),
        .ptr_gray_out   (gray_r),
        .flag_out       (flag_r),
        .level_out      (level_r)
    );

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b = '0;
        for (int i = 4; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == 4) ? 1'b0 : b[i+1]);
        end
        return b;
    endfunction

    task automatic model_reset();
        mb_w = '0; ms0_w = '0; ms1_w = '0; mf_w = 1'b0;
        mb_r = '0; ms0_r = '0; ms1_r = '0; mf_r = 1'b1;
        q_w.delete();
        q_r.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid_w = 1'b0; valid_r = 1'b0;
        remote_w = '0;  remote_r = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step_wr(input logic v, input logic [4:0] rg, output logic acc_dut);
        exp_t e;
        logic [4:0] rb, nb;
        logic acc;
        @(negedge clk);
        valid_w  = v;
        remote_w = rg;
        acc_dut  = v & ready_w;
        rb  = g2b(ms1_w);
        acc = v & ~mf_w;
        nb  = mb_w + {4'b0, acc};
        e.addr  = nb[3:0];
        e.gray  = b2g(nb);
        e.level = nb - rb;
        e.flag  = (e.level == 5'd16);
        q_w.push_back(e);
        mb_w = nb; mf_w = e.flag; ms1_w = ms0_w; ms0_w = rg;
        @(posedge clk);
        #1;
        e = q_w.pop_front();
        checks += 5;
        if (addr_w !== e.addr) begin
            errors++; $display("FAIL wr_addr actual=%h required=%h", addr_w, e.addr);
        end
        if (gray_w !== e.gray) begin
            errors++; $display("FAIL wr_gray actual=%b required=%b", gray_w, e.gray);
        end
        if (flag_w !== e.flag) begin
            errors++; $display("FAIL wr_full actual=%b required=%b", flag_w, e.flag);
        end
        if (level_w !== e.level) begin
            errors++; $display("FAIL wr_level actual=%0d required=%0d", level_w, e.level);
        end
        if (ready_w !== ~e.flag) begin
            errors++; $display("FAIL wr_ready actual=%b required=%b", ready_w, ~e.flag);
        end
    endtask

    task automatic step_rd(input logic v, input logic [4:0] rg);
        exp_t e;
        logic [4:0] rb, nb;
        logic acc;
        @(negedge clk);
        valid_r  = v;
        remote_r = rg;
        rb  = g2b(ms1_r);
        acc = v & ~mf_r;
        nb  = mb_r + {4'b0, acc};
        e.addr  = nb[3:0];
        e.gray  = b2g(nb);
        e.level = rb - nb;
        e.flag  = (e.level == 5'd0);
        q_r.push_back(e);
        mb_r = nb; mf_r = e.flag; ms1_r = ms0_r; ms0_r = rg;
        @(posedge clk);
        #1;
        e = q_r.pop_front();
        checks += 5;
        if (addr_r !== e.addr) begin
            errors++; $display("FAIL rd_addr actual=%h required=%h", addr_r, e.addr);
        end
        if (gray_r !== e.gray) begin
            errors++; $display("FAIL rd_gray actual=%b required=%b", gray_r, e.gray);
        end
        if (flag_r !== e.flag) begin
            errors++; $display("FAIL rd_empty actual=%b required=%b", flag_r, e.flag);
        end
        if (level_r !== e.level) begin
            errors++; $display("FAIL rd_level actual=%0d required=%0d", level_r, e.level);
        end
        if (ready_r !== ~e.flag) begin
            errors++; $display("FAIL rd_ready actual=%b required=%b", ready_r, ~e.flag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 10;
        if (addr_w !== 4'd0)  begin errors++; $display("FAIL %s wr_addr actual=%h required=0", tag, addr_w); end
        if (gray_w !== 5'd0)  begin errors++; $display("FAIL %s wr_gray actual=%b required=00000", tag, gray_w); end
        if (flag_w !== 1'b0)  begin errors++; $display("FAIL %s wr_full actual=%b required=0", tag, flag_w); end
        if (level_w !== 5'd0) begin errors++; $display("FAIL %s wr_level actual=%0d required=0", tag, level_w); end
        if (ready_w !== 1'b1) begin errors++; $display("FAIL %s wr_ready actual=%b required=1", tag, ready_w); end
        if (addr_r !== 4'd0)  begin errors++; $display("FAIL %s rd_addr actual=%h required=0", tag, addr_r); end
        if (gray_r !== 5'd0)  begin errors++; $display("FAIL %s rd_gray actual=%b required=00000", tag, gray_r); end
        if (flag_r !== 1'b1)  begin errors++; $display("FAIL %s rd_empty actual=%b required=1", tag, flag_r); end
        if (level_r !== 5'd0) begin errors++; $display("FAIL %s rd_level actual=%0d required=0", tag, level_r); end
        if (ready_r !== 1'b0) begin errors++; $display("FAIL %s rd_ready actual=%b required=0", tag, ready_r); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_w = 1'b0; valid_r = 1'b0;
        remote_w = '0;  remote_r = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_release");
    endtask

    task automatic test_write_fill();
        int n = 0;
        logic a;
        for (int i = 0; i < 20; i++) begin
            step_wr(1'b1, 5'b00000, a);
            n += int'(a);
        end
        checks += 5;
        if (n != 16) begin errors++; $display("FAIL fill_accepts actual=%0d required=16", n); end
        if (gray_w !== 5'b11000) begin errors++; $display("FAIL fill_gray actual=%b required=11000", gray_w); end
        if (level_w !== 5'd16) begin errors++; $display("FAIL fill_level actual=%0d required=16", level_w); end
        if (flag_w !== 1'b1) begin errors++; $display("FAIL fill_full actual=%b required=1", flag_w); end
        if (ready_w !== 1'b0) begin errors++; $display("FAIL fill_ready actual=%b required=0", ready_w); end
    endtask

    task automatic test_stall();
        logic a;
        int n = 0;
        for (int i = 0; i < 10; i++) begin
            step_wr(1'b1, 5'b00000, a);
            n += int'(a);
        end
        checks += 4;
        if (n != 0) begin errors++; $display("FAIL stall_accepts actual=%0d required=0", n); end
        if (gray_w !== 5'b11000) begin errors++; $display("FAIL stall_gray actual=%b required=11000", gray_w); end
        if (addr_w !== 4'd0) begin errors++; $display("FAIL stall_addr actual=%h required=0", addr_w); end
        if (level_w !== 5'd16) begin errors++; $display("FAIL stall_level actual=%0d required=16", level_w); end
    endtask

    task automatic test_write_drain();
        logic a;
        logic f [3];
        for (int i = 0; i < 3; i++) begin
            step_wr(1'b0, 5'b00001, a);
            f[i] = flag_w;
        end
        checks += 4;
        if (f[0] !== 1'b1) begin errors++; $display("FAIL drain_edge1 actual=%b required=1", f[0]); end
        if (f[1] !== 1'b1) begin errors++; $display("FAIL drain_edge2 actual=%b required=1", f[1]); end
        if (f[2] !== 1'b0) begin errors++; $display("FAIL drain_edge3 actual=%b required=0", f[2]); end
        if (level_w !== 5'd15) begin errors++; $display("FAIL drain_level actual=%0d required=15", level_w); end
    endtask

    task automatic test_read_avail();
        checks += 2;
        if (flag_r !== 1'b1) begin errors++; $display("FAIL rd_init_empty actual=%b required=1", flag_r); end
        if (level_r !== 5'd0) begin errors++; $display("FAIL rd_init_level actual=%0d required=0", level_r); end
        for (int i = 0; i < 3; i++) step_rd(1'b0, 5'b00010);
        checks += 2;
        if (flag_r !== 1'b0) begin errors++; $display("FAIL rd_avail_empty actual=%b required=0", flag_r); end
        if (level_r !== 5'd3) begin errors++; $display("FAIL rd_avail_level actual=%0d required=3", level_r); end
        for (int i = 0; i < 3; i++) begin
            step_rd(1'b1, 5'b00010);
            checks++;
            if (addr_r !== 4'(i + 1)) begin
                errors++; $display("FAIL rd_addr_step actual=%0d required=%0d", addr_r, i + 1);
            end
        end
        step_rd(1'b0, 5'b00010);
        checks += 2;
        if (flag_r !== 1'b1) begin errors++; $display("FAIL rd_drained_empty actual=%b required=1", flag_r); end
        if (level_r !== 5'd0) begin errors++; $display("FAIL rd_drained_level actual=%0d required=0", level_r); end
    endtask

    task automatic test_wrap();
        logic a;
        logic [4:0] prev, lag1, lag2;
        int n = 0;
        bit wrapped = 0;
        do_reset();
        prev = 5'b0; lag1 = 5'b0; lag2 = 5'b0;
        for (int i = 0; i < 40; i++) begin
            step_wr(1'b1, lag2, a);
            n += int'(a);
            checks += 2;
            if ($countones(gray_w ^ prev) != 1) begin
                errors++; $display("FAIL wrap_onebit actual=%b required_from=%b", gray_w, prev);
            end
            if (flag_w !== 1'b0) begin
                errors++; $display("FAIL wrap_false_full actual=%b required=0", flag_w);
            end
            if (prev == 5'b10000 && gray_w == 5'b00000) wrapped = 1;
            prev = gray_w;
            lag2 = lag1;
            lag1 = b2g(mb_w);
        end
        checks += 2;
        if (n != 40) begin errors++; $display("FAIL wrap_accepts actual=%0d required=40", n); end
        if (!wrapped) begin errors++; $display("FAIL wrap_seen actual=0 required=1"); end
    endtask

    task automatic test_reset_mid();
        logic a;
        do_reset();
        for (int i = 0; i < 7; i++) step_wr(1'b1, 5'b00000, a);
        @(negedge clk);
        valid_w = 1'b0;
        checks++;
        if (level_w !== 5'd7) begin errors++; $display("FAIL mid_level actual=%0d required=7", level_w); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step_wr(1'b1, 5'b00000, a);
        checks++;
        if (addr_w !== 4'd1) begin errors++; $display("FAIL mid_first_addr actual=%h required=1", addr_w); end
    endtask

    initial begin
        test_reset();
        test_write_fill();
        test_stall();
        test_write_drain();
        test_read_avail();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
